// File: rtl/vga_pkg.sv
// Shared VGA timing constants, derived totals/sync offsets and the pixel colour type.
// Default values describe 640x480 @ 60 Hz with a 25 MHz pixel clock.
package vga_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
  localparam int VGA_HS_START = VGA_H_ACTIVE + VGA_H_FP;
  localparam int VGA_HS_END   = VGA_HS_START + VGA_H_SYNC;
  localparam int VGA_VS_START = VGA_V_ACTIVE + VGA_V_FP;
  localparam int VGA_VS_END   = VGA_VS_START + VGA_V_SYNC;

  localparam int VGA_CNT_W    = 10;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Half-open interval test lo <= v < hi on counter-width values.
  function automatic logic in_range(input logic [VGA_CNT_W-1:0] v,
                                    input logic [VGA_CNT_W-1:0] lo,
                                    input logic [VGA_CNT_W-1:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-N counter with enable; tc flags the last count (N-1) so the caller can cascade.
module mod_counter #(
  parameter int N = 800,
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);

  localparam int           LAST_I = N - 1;
  localparam logic [W-1:0] LAST   = LAST_I[W-1:0];
  localparam int           ONE_I  = 1;
  localparam logic [W-1:0] ONE    = ONE_I[W-1:0];

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: hold, wrap at N-1, or increment.
  always_comb begin
    cnt_d = cnt_q;
    if (!en) begin
      cnt_d = cnt_q;
    end else if (cnt_q == LAST) begin
      cnt_d = {W{1'b0}};
    end else begin
      cnt_d = cnt_q + ONE;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: half-rate pixel clock, h/v counters, and DAC outputs delayed
// one pixel behind x,y so the video generator sees zero-latency coordinates.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           r_in,
  input  logic [7:0]           g_in,
  input  logic [7:0]           b_in,
  output logic [VGA_CNT_W-1:0] x,
  output logic [VGA_CNT_W-1:0] y,
  output logic [7:0]           vga_r,
  output logic [7:0]           vga_g,
  output logic [7:0]           vga_b,
  output logic                 vga_hsync,
  output logic                 vga_vsync,
  output logic                 vga_blank_n,
  output logic                 vga_sync_n,
  output logic                 vga_clk,
  output logic                 frame_start
);

  localparam int CW       = VGA_CNT_W;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  localparam logic [CW-1:0] H_ACT_C = H_ACTIVE[CW-1:0];
  localparam logic [CW-1:0] V_ACT_C = V_ACTIVE[CW-1:0];
  localparam logic [CW-1:0] HS_S_C  = HS_START[CW-1:0];
  localparam logic [CW-1:0] HS_E_C  = HS_END[CW-1:0];
  localparam logic [CW-1:0] VS_S_C  = VS_START[CW-1:0];
  localparam logic [CW-1:0] VS_E_C  = VS_END[CW-1:0];

  logic          p_q;
  logic          v_en_s;
  logic [CW-1:0] h_cnt_s;
  logic [CW-1:0] v_cnt_s;
  logic          h_tc_s;
  logic          v_tc_s;
  logic          active_s;
  logic          hsync_d, vsync_d, frame_d;
  logic          hsync_q, vsync_q, blank_q, frame_q;
  rgb_t          pix_s, rgb_d, rgb_q;

  // p_q high means the coming clk edge is a pixel edge (vga_clk about to fall).
  assign v_en_s = p_q & h_tc_s;

  mod_counter #(.N(H_TOTAL), .W(CW)) u_h_cnt (
    .clk (clk),
    .rst (rst),
    .en  (p_q),
    .cnt (h_cnt_s),
    .tc  (h_tc_s)
  );

  mod_counter #(.N(V_TOTAL), .W(CW)) u_v_cnt (
    .clk (clk),
    .rst (rst),
    .en  (v_en_s),
    .cnt (v_cnt_s),
    .tc  (v_tc_s)
  );

  // Decode the current pixel into the values captured at the next pixel edge.
  always_comb begin
    pix_s    = {r_in, g_in, b_in};
    active_s = (h_cnt_s < H_ACT_C) && (v_cnt_s < V_ACT_C);
    hsync_d  = ~in_range(h_cnt_s, HS_S_C, HS_E_C);
    vsync_d  = ~in_range(v_cnt_s, VS_S_C, VS_E_C);
    frame_d  = p_q & h_tc_s & v_tc_s;
    rgb_d    = 24'h000000;
    if (active_s) begin
      rgb_d = pix_s;
    end else begin
      rgb_d = 24'h000000;
    end
  end

  // Pixel-clock toggle, one-clk frame pulse, and pixel-edge output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_q     <= 1'b0;
      frame_q <= 1'b0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      blank_q <= 1'b0;
      rgb_q   <= 24'h000000;
    end else begin
      p_q     <= ~p_q;
      frame_q <= frame_d;
      if (p_q) begin
        hsync_q <= hsync_d;
        vsync_q <= vsync_d;
        blank_q <= active_s;
        rgb_q   <= rgb_d;
      end
    end
  end

  assign x           = h_cnt_s;
  assign y           = v_cnt_s;
  assign vga_r       = rgb_q.r;
  assign vga_g       = rgb_q.g;
  assign vga_b       = rgb_q.b;
  assign vga_hsync   = hsync_q;
  assign vga_vsync   = vsync_q;
  assign vga_blank_n = blank_q;
  assign vga_sync_n  = 1'b0;
  assign vga_clk     = p_q;
  assign frame_start = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen on a shrunken raster (16x12 total) so whole
// frames fit in a short run; expectations come from elapsed-clock arithmetic.
module tb_vga_timing_gen;

  localparam int HA = 8;
  localparam int HF = 2;
  localparam int HS = 3;
  localparam int HB = 3;
  localparam int VA = 5;
  localparam int VF = 2;
  localparam int VS = 2;
  localparam int VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] r_in, g_in, b_in;
  logic [9:0] x, y;
  logic [7:0] vga_r, vga_g, vga_b;
  logic       vga_hsync, vga_vsync, vga_blank_n, vga_sync_n, vga_clk, frame_start;

  int          checks = 0;
  int          errors = 0;
  int          n;         // clk edges since reset released
  int          tot = 0;   // absolute clk edges
  int          last_fs;
  int          hs_run;
  int          bl_run;
  logic [23:0] cap;       // colour presented at the most recent pixel edge
  bit          found;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk), .rst(rst), .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .x(x), .y(y), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_blank_n(vga_blank_n),
    .vga_sync_n(vga_sync_n), .vga_clk(vga_clk), .frame_start(frame_start)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pixel k = n/2 is on x,y; the DAC shows pixel k-1 with the colour sampled at edge 2k.
  task automatic check_model();
    int          k, pk, px, py;
    bit          act;
    logic        e_hs, e_vs, e_bl, e_fs;
    logic [23:0] e_rgb;
    k = n / 2;
    chk("x", x, k % HT);
    chk("y", y, (k / HT) % VT);
    chk("vga_clk", vga_clk, n % 2);
    chk("sync_n", vga_sync_n, 0);
    if (k == 0) begin
      e_hs = 1'b1; e_vs = 1'b1; e_bl = 1'b0; e_rgb = 24'h0; e_fs = 1'b0;
    end else begin
      pk    = k - 1;
      px    = pk % HT;
      py    = (pk / HT) % VT;
      act   = (px < HA) && (py < VA);
      e_hs  = !((px >= HA + HF) && (px < HA + HF + HS));
      e_vs  = !((py >= VA + VF) && (py < VA + VF + VS));
      e_bl  = act;
      e_rgb = act ? cap : 24'h0;
      e_fs  = (n % 2 == 0) && (k % (HT * VT) == 0);
    end
    chk("hsync", vga_hsync, e_hs);
    chk("vsync", vga_vsync, e_vs);
    chk("blank_n", vga_blank_n, e_bl);
    chk("rgb", {vga_r, vga_g, vga_b}, e_rgb);
    chk("frame_start", frame_start, e_fs);
    if (vga_hsync === 1'b0) hs_run++;
    else if (hs_run > 0) begin
      chk("hsync_len", hs_run, 2 * HS);
      hs_run = 0;
    end
    if (vga_blank_n === 1'b1) bl_run++;
    else if (bl_run > 0) begin
      chk("blank_len", bl_run, 2 * HA);
      bl_run = 0;
    end
    if (frame_start === 1'b1) begin
      if (last_fs >= 0) chk("frame_period", tot - last_fs, 2 * HT * VT);
      last_fs = tot;
    end
  endtask

  task automatic tick(input bit ff);
    if (ff) begin
      r_in = 8'hFF; g_in = 8'hFF; b_in = 8'hFF;
    end else begin
      r_in = 8'($urandom); g_in = 8'($urandom); b_in = 8'($urandom);
    end
    if (n % 2 == 1) cap = {r_in, g_in, b_in};
    @(posedge clk);
    n++;
    tot++;
    @(negedge clk);
    check_model();
  endtask

  task automatic do_reset(input int cyc);
    rst = 1'b1;
    repeat (cyc) begin
      @(posedge clk);
      tot++;
    end
    @(negedge clk);
    rst     = 1'b0;
    n       = 0;
    hs_run  = 0;
    bl_run  = 0;
    last_fs = -1;
    cap     = 24'h0;
    check_model();
  endtask

  initial begin
    rst  = 1'b1;
    r_in = 8'h00; g_in = 8'h00; b_in = 8'h00;
    n    = 0;
    do_reset(3);

    // Two full frames plus a little, random colours.
    repeat (4 * HT * VT + 40) tick(1'b0);

    // Walk to pixel (5,3) and pulse reset for a single clk there.
    found = 1'b0;
    for (int i = 0; i < 4 * HT * VT && !found; i++) begin
      if (n % 2 == 0 && (n / 2) % HT == 5 && ((n / 2) / HT) % VT == 3) found = 1'b1;
      else tick(1'b0);
    end
    chk("reach_5_3", found, 1);
    do_reset(1);

    // Constant white through more than one frame.
    repeat (2 * HT * VT + 4 * HT) tick(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameters H_ACTIVE 640, H_FP 16, H_SYNC 96, H_BP 48, V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33; each value is in pixels for H_* and lines for V_*.
REQ-002 SHALL have clk  in  1  system clock (50 MHz); sole clock.
REQ-003 SHALL have rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have r_in, g_in, b_in  in  8 each  pixel colour from the video generator for the current x,y.
REQ-005 SHALL have x, y  out  10 each  current horizontal/vertical counter value, fed to the video generator.
REQ-006 SHALL have vga_r, vga_g, vga_b  out  8 each  registered DAC colour.
REQ-007 SHALL have vga_hsync, vga_vsync  out  1  active-low syncs.
REQ-008 SHALL have vga_blank_n  out  1  high during the active area.
REQ-009 SHALL have vga_sync_n  out  1  tied 0.
REQ-010 SHALL have vga_clk  out  1  25 MHz pixel clock to the DAC.
REQ-011 SHALL have frame_start  out  1  one-clk pulse at frame origin.

Function
REQ-012 SHALL hold an internal toggle flop p; p toggles every clk; vga_clk = p.
REQ-013 SHALL advance counters and output registers only on clk edges where p==1 (pixel edge), so outputs change while vga_clk falls and stay stable one full clk before it rises.
REQ-014 SHALL count h_cnt 0..H_TOTAL-1 (800), wrapping to 0; H_TOTAL = sum of H_*.
REQ-015 SHALL increment v_cnt only on the pixel edge where h_cnt==799; v_cnt counts 0..524 and wraps to 0.
REQ-016 SHALL drive x=h_cnt and y=v_cnt combinationally with no clipping, so video-generator latency is zero cycles.
REQ-017 SHALL, on each pixel edge, register active = (h_cnt<640 && v_cnt<480) into vga_blank_n.
REQ-018 SHALL, on each pixel edge, register vga_hsync = ~(656<=h_cnt<752).
REQ-019 SHALL, on each pixel edge, register vga_vsync = ~(490<=v_cnt<492).
REQ-020 SHALL, on each pixel edge, register vga_r/g/b = active ? r_in/g_in/b_in : 0.
REQ-021 SHALL delay all DAC outputs by exactly one pixel relative to x,y; syncs, blank and colour SHALL stay mutually aligned.
REQ-022 SHALL assert frame_start for exactly one clk, on the clk following the pixel edge at which counters wrap from (799,524) to (0,0).
REQ-023 SHALL treat all bounds as derived from the parameters; no hard-coded numbers in logic.

Reset
REQ-024 SHALL, while rst=1 at a clk edge, set p=0, h_cnt=v_cnt=0, vga_hsync=vga_vsync=1, vga_blank_n=0, vga_r/g/b=0, frame_start=0.
REQ-025 SHALL, when rst asserts mid-frame, return to the state in REQ-024 on the next edge, with no partial sync pulse and no frame_start.
REQ-026 SHALL make the first pixel edge occur on the second clk edge after rst deasserts.

Structure
REQ-027 SHALL place the timing constants, the derived totals and the sync start/end offsets in shared package vga_pkg.
REQ-028 SHALL place the rgb_t struct (r, g, b, 8 bits each) in shared package vga_pkg.
REQ-029 SHALL instantiate sub-module mod_counter twice: parameter N, inputs clk, rst and en, outputs cnt and tc (terminal count), for horizontal and vertical.

Verification
REQ-030 Reset release -> p toggles every clk; x goes 0→1 at the 2nd edge and 1→2 at the 4th edge.
REQ-031 Steady state -> vga_hsync low for exactly 192 clk per line, falling one pixel after x reaches 656; line period 1600 clk.
REQ-032 Full frame -> frame_start pulses exactly 840000 clk apart; vga_vsync low for exactly 3200 clk, starting one pixel after y reaches 490.
REQ-033 r_in=g_in=b_in=FF constant -> vga_r=FF for exactly 640 consecutive pixels per visible line, otherwise 00; vga_blank_n matches it; rows 480..524 are all 00.
REQ-034 Counters at (799,524) -> next pixel edge gives (0,0); frame_start is high for one clk only.
REQ-035 rst pulsed for one clk at x=300, y=200 -> next edge gives x=y=0, hsync=vsync=1, rgb=0, and no frame_start pulse.
